cdr_frame_sync: RTL

CDR_FRAME_SYNC -- requirements
Module: cdr_frame_sync

---
 rtl/cdr_frame_sync.sv | 94 +++++++++
 1 files changed

// File: rtl/cdr_frame_sync.sv
// cdr_frame_sync: hunts for SYNC_WORD in the recovered bit stream, emits PAYLOAD_LEN-byte
// frames MSB-first, and verifies the sync byte after each frame with a MAX_MISS flywheel.
module cdr_frame_sync #(
  parameter logic [7:0]  SYNC_WORD   = 8'hA7,
  parameter int unsigned PAYLOAD_LEN = 4,
  parameter int unsigned MAX_MISS    = 2
) (
  input  logic       clk_x8,
  input  logic       rst_n,
  input  logic       d_in,
  input  logic       d_in_valid,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);
  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;
  state_t     state_q;
  logic [7:0] sr_q, sr_d, byte_cnt_q;
  logic [3:0] fill_q, fill_d, miss_q, miss_d;
  logic [2:0] bit_q;
  logic       sync_hit, last_byte;
  assign sr_d      = {sr_q[6:0], d_in};
  assign fill_d    = (fill_q == 4'd8) ? fill_q : fill_q + 4'd1;
  assign miss_d    = miss_q + 4'd1;
  assign sync_hit  = sr_d == SYNC_WORD;
  assign last_byte = byte_cnt_q == 8'(PAYLOAD_LEN - 1);
  always_ff @(posedge clk_x8 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      sr_q        <= 8'd0;
      byte_cnt_q  <= 8'd0;
      fill_q      <= 4'd0;
      miss_q      <= 4'd0;
      bit_q       <= 3'd0;
      byte_out    <= 8'd0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      if (d_in_valid) begin
        sr_q <= sr_d;
        case (state_q)
          HUNT: begin
            fill_q <= fill_d;
            // a match only counts once eight fresh bits have entered since entering HUNT
            if (sync_hit && fill_d == 4'd8) begin
              state_q    <= PAYLOAD;
              bit_q      <= 3'd0;
              byte_cnt_q <= 8'd0;
            end
          end
          PAYLOAD: begin
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              byte_out    <= sr_d;
              byte_valid  <= 1'b1;
              frame_start <= byte_cnt_q == 8'd0;
              byte_cnt_q  <= last_byte ? 8'd0 : byte_cnt_q + 8'd1;
              state_q     <= last_byte ? CHECK : PAYLOAD;
            end
          end
          CHECK: begin
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (sync_hit) begin
                miss_q  <= 4'd0;
                locked  <= 1'b1;
                state_q <= PAYLOAD;
              end else if (!locked || miss_d == 4'(MAX_MISS)) begin
                // an unconfirmed first check drops silently; a locked link reports its final miss
                sync_err <= locked;
                locked   <= 1'b0;
                miss_q   <= 4'd0;
                fill_q   <= 4'd0;
                state_q  <= HUNT;
              end else begin
                sync_err <= 1'b1;
                miss_q   <= miss_d;
                state_q  <= PAYLOAD;
              end
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end
endmodule
